ct_hex_pager: RTL

CT_HEX_PAGER -- requirements
Module: ct_hex_pager

---
 rtl/ct_hex_pager.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ct_hex_pager.sv
// Ciphertext pager: holds one 128-bit AES word and shows it six nibbles at a time
// on seven-segment digits, paged by a debounced key. CT_PAGER_AUTO_EN adds timed paging.
`timescale 1ns/1ps
module ct_hex_pager #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int AUTO_CYCLES     = 100000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ct_valid,
  input  logic [127:0] ct_data,
  output logic         ct_ready,
  input  logic         key_next_n,
  output logic [6:0]   hex0,
  output logic [6:0]   hex1,
  output logic [6:0]   hex2,
  output logic [6:0]   hex3,
  output logic [6:0]   hex4,
  output logic [6:0]   hex5,
  output logic [2:0]   page,
  output logic         loaded
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic {EMPTY = 1'b0, SHOW = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            ready_q;
  logic [127:0]    word_q, word_d;
  logic [2:0]      page_q, page_d;
  logic            loaded_q, loaded_d;
  logic [5:0][6:0] hex_q, hex_d;

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic [1:0]      settle_q;
  logic            arm_q, arm_d;

  logic            transfer, deb_fire, key_adv, auto_adv, advance;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  assign transfer = ct_valid & ready_q;

  // The debounced level moves only after DEBOUNCE_CYCLES samples in a row disagree with it.
  always_comb begin
    deb_fire  = (sync2_q != stable_q) && (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1));
    stable_d  = stable_q;
    deb_cnt_d = '0;
    if (deb_fire)
      stable_d = sync2_q;
    else if (sync2_q != stable_q)
      deb_cnt_d = deb_cnt_q + DW'(1);
  end

  // A key must be seen released after reset before a press may advance the page;
  // settle_q marks when sync2_q carries a real sample instead of its reset value.
  assign arm_d   = arm_q | (settle_q[1] & sync2_q);
  assign key_adv = deb_fire & ~sync2_q & arm_q;

`ifdef CT_PAGER_AUTO_EN
  localparam int AW = $clog2(AUTO_CYCLES + 1);
  logic [AW-1:0] auto_cnt_q, auto_cnt_d;

  always_comb begin
    auto_cnt_d = '0;
    auto_adv   = 1'b0;
    if (state_q == SHOW && !transfer && !key_adv) begin
      if (auto_cnt_q == AW'(AUTO_CYCLES - 1))
        auto_adv = 1'b1;
      else
        auto_cnt_d = auto_cnt_q + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) auto_cnt_q <= '0;
    else     auto_cnt_q <= auto_cnt_d;
  end
`else
  logic unused_auto;
  assign unused_auto = (AUTO_CYCLES != 0);
  assign auto_adv    = 1'b0;
`endif

  assign advance = key_adv | auto_adv;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    page_d   = page_q;
    loaded_d = loaded_q;
    case (state_q)
      EMPTY: begin
        if (transfer) begin
          state_d  = SHOW;
          word_d   = ct_data;
          page_d   = 3'd0;
          loaded_d = 1'b1;
        end
      end
      SHOW: begin
        if (transfer) begin
          word_d = ct_data;
          page_d = 3'd0;
        end else if (advance) begin
          page_d = (page_q == 3'd5) ? 3'd0 : page_q + 3'd1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Digits are computed from next-state values so they change on the same edge as page.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_digit
      logic [5:0] nib_idx;
      logic [3:0] nib;
      assign nib_idx   = 6'(page_d) * 6'd6 + 6'(gi);
      assign nib       = word_d[{nib_idx[4:0], 2'b00} +: 4];
      assign hex_d[gi] = (state_d == EMPTY) ? 7'h3F :
                         nib_idx[5]         ? 7'h7F : seg7(nib);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      ready_q   <= 1'b0;
      word_q    <= '0;
      page_q    <= 3'd0;
      loaded_q  <= 1'b0;
      hex_q     <= {6{7'h3F}};
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      stable_q  <= 1'b1;
      deb_cnt_q <= '0;
      settle_q  <= 2'b00;
      arm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= 1'b1;
      word_q    <= word_d;
      page_q    <= page_d;
      loaded_q  <= loaded_d;
      hex_q     <= hex_d;
      sync1_q   <= key_next_n;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      deb_cnt_q <= deb_cnt_d;
      settle_q  <= {settle_q[0], 1'b1};
      arm_q     <= arm_d;
    end
  end

  assign ct_ready = ready_q;
  assign page     = page_q;
  assign loaded   = loaded_q;
  assign hex0     = hex_q[0];
  assign hex1     = hex_q[1];
  assign hex2     = hex_q[2];
  assign hex3     = hex_q[3];
  assign hex4     = hex_q[4];
  assign hex5     = hex_q[5];

endmodule
